// File: rtl/sfm_minmax_reducer.sv
// sfm_minmax_reducer: streaming FP min/max reduction over N_LANES-wide beats; define SFM_REDUCER_ARGIDX_EN to add idx_o (arg-min/arg-max)
package sfm_pkg;
  typedef enum logic [1:0] {BEFORE, AFTER, AROUND} regs_config_t;
  typedef enum logic {MIN, MAX} min_max_mode_t;
endpackage

module sfm_minmax_reducer
  import sfm_pkg::*;
#(
  parameter int           N_LANES     = 4,
  parameter int           WIDTH       = 16,
  parameter int           EXP_BITS    = 5,
  parameter regs_config_t REGS_CONFIG = AROUND,
  parameter int           IDX_W       = 16
) (
  input  logic                       clk_i,
  input  logic                       rst_ni,
  input  logic                       clear_i,
  input  min_max_mode_t              mode_i,
  input  logic                       valid_i,
  output logic                       ready_o,
  input  logic [N_LANES*WIDTH-1:0]   data_i,
  input  logic [N_LANES-1:0]         strb_i,
  input  logic                       last_i,
  output logic                       valid_o,
  input  logic                       ready_i,
  output logic [WIDTH-1:0]           data_o,
  output logic                       empty_o
`ifdef SFM_REDUCER_ARGIDX_EN
  ,
  output logic [IDX_W-1:0]           idx_o
`endif
);
  localparam int LG = $clog2(N_LANES);
  localparam int NN = 2*N_LANES-1;
  localparam int MW = WIDTH-EXP_BITS-1;
  localparam logic [WIDTH-1:0] QNAN = {1'b0, {EXP_BITS{1'b1}}, 1'b1, {(MW-1){1'b0}}};
  localparam logic HAS_IN = REGS_CONFIG != AFTER;
  localparam logic HAS_OUT = REGS_CONFIG != BEFORE;

  typedef enum logic [1:0] {IDLE, ACC, DONE} state_t;

  if (IDX_W <= LG) begin : g_idx_w_chk
    $error("IDX_W too narrow to index one beat of N_LANES");
  end

  // Sign-magnitude to two's complement so that -0 and +0 share key 0
  function automatic logic signed [WIDTH-1:0] key(input logic [WIDTH-1:0] v);
    logic signed [WIDTH-1:0] m;
    m = $signed({1'b0, v[WIDTH-2:0]});
    return v[WIDTH-1] ? -m : m;
  endfunction

  // Strictly better only, so equal values keep the earlier (lower-index) element
  function automatic logic better(input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b, input logic mx);
    return mx ? (key(a) > key(b)) : (key(a) < key(b));
  endfunction

  function automatic logic is_nan(input logic [WIDTH-1:0] v);
    return (&v[WIDTH-2 -: EXP_BITS]) && (|v[MW-1:0]);
  endfunction

  state_t r_state, w_next;
  logic [WIDTH-1:0] r_acc;
  logic r_found;
  min_max_mode_t r_mode;
  logic w_cv, w_cl, w_core_rdy, w_take, w_first, w_ohs, w_mx;
  logic [N_LANES*WIDTH-1:0] w_cd;
  logic [N_LANES-1:0] w_cs;
  min_max_mode_t w_cm;
  logic [WIDTH-1:0] w_nv [NN];
  logic w_nq [NN];
  logic w_pick, w_nf;
  logic [WIDTH-1:0] w_win;

  assign w_core_rdy = r_state != DONE;
  assign w_take = w_cv & w_core_rdy;
  assign w_first = r_state == IDLE;
  assign w_mx = (w_first ? w_cm : r_mode) == MAX;
  assign w_ohs = valid_o & ready_i;

  if (HAS_IN) begin : g_in
    logic r_iv, r_il;
    logic [N_LANES*WIDTH-1:0] r_id;
    logic [N_LANES-1:0] r_is;
    min_max_mode_t r_im;
    // Input register: refills when empty or when the core drains it in the same cycle
    always_ff @(posedge clk_i or negedge rst_ni)
      if (!rst_ni) begin
        r_iv <= 1'b0;
        r_il <= 1'b0;
        r_id <= '0;
        r_is <= '0;
        r_im <= MIN;
      end else if (clear_i) r_iv <= 1'b0;
      else if (valid_i && ready_o) begin
        r_iv <= 1'b1;
        r_il <= last_i;
        r_id <= data_i;
        r_is <= strb_i;
        r_im <= mode_i;
      end else if (w_take) r_iv <= 1'b0;
    assign w_cv = r_iv;
    assign w_cl = r_il;
    assign w_cd = r_id;
    assign w_cs = r_is;
    assign w_cm = r_im;
    assign ready_o = rst_ni & (~r_iv | w_core_rdy);
  end else begin : g_no_in
    assign w_cv = valid_i;
    assign w_cl = last_i;
    assign w_cd = data_i;
    assign w_cs = strb_i;
    assign w_cm = mode_i;
    assign ready_o = rst_ni & w_core_rdy;
  end

`ifdef SFM_REDUCER_ARGIDX_EN
  logic [IDX_W-1:0] w_ni [NN];
`endif

  // Heap-ordered lane tree: leaves at N_LANES-1.., left child always holds the lower lanes
  always_comb begin
    logic w_sel;
    w_sel = 1'b0;
    for (int l = 0; l < N_LANES; l++) begin
      w_nv[N_LANES-1+l] = w_cd[l*WIDTH +: WIDTH];
      w_nq[N_LANES-1+l] = w_cs[l] & ~is_nan(w_cd[l*WIDTH +: WIDTH]);
`ifdef SFM_REDUCER_ARGIDX_EN
      w_ni[N_LANES-1+l] = IDX_W'(l);
`endif
    end
    for (int k = N_LANES-2; k >= 0; k--) begin
      w_sel = w_nq[2*k+2] & (~w_nq[2*k+1] | better(w_nv[2*k+2], w_nv[2*k+1], w_mx));
      w_nv[k] = w_sel ? w_nv[2*k+2] : w_nv[2*k+1];
      w_nq[k] = w_nq[2*k+1] | w_nq[2*k+2];
`ifdef SFM_REDUCER_ARGIDX_EN
      w_ni[k] = w_sel ? w_ni[2*k+2] : w_ni[2*k+1];
`endif
    end
  end

  assign w_pick = w_nq[0] & (w_first | ~r_found | better(w_nv[0], r_acc, w_mx));
  assign w_nf = w_nq[0] | (~w_first & r_found);
  assign w_win = w_pick ? w_nv[0] : r_acc;

  // Accumulator: the first beat overwrites, later beats merge; no qualifier leaves canonical qNaN
  always_ff @(posedge clk_i or negedge rst_ni)
    if (!rst_ni) begin
      r_acc <= '0;
      r_found <= 1'b0;
      r_mode <= MIN;
    end else if (w_take) begin
      r_acc <= w_nf ? w_win : QNAN;
      r_found <= w_nf;
      r_mode <= w_first ? w_cm : r_mode;
    end

`ifdef SFM_REDUCER_ARGIDX_EN
  logic [IDX_W-1:0] r_bcnt, r_aidx, w_gidx;
  assign w_gidx = (w_first ? '0 : (r_bcnt << LG)) + w_ni[0];
  // Beat counter saturates so indices never alias back to the start of the stream
  always_ff @(posedge clk_i or negedge rst_ni)
    if (!rst_ni) begin
      r_bcnt <= '0;
      r_aidx <= '0;
    end else if (w_take) begin
      r_bcnt <= w_first ? IDX_W'(1) : (&r_bcnt ? r_bcnt : r_bcnt + 1'b1);
      r_aidx <= w_nf ? (w_pick ? w_gidx : r_aidx) : '0;
    end
`endif

  // Core state register
  always_ff @(posedge clk_i or negedge rst_ni)
    if (!rst_ni) r_state <= IDLE;
    else r_state <= w_next;

  // Next state; clear overrides any handshake in the same cycle
  always_comb begin
    w_next = r_state;
    case (r_state)
      IDLE: if (w_take) w_next = w_cl ? DONE : ACC;
      ACC: if (w_take && w_cl) w_next = DONE;
      DONE: if (w_ohs) w_next = IDLE;
      default: w_next = IDLE;
    endcase
    if (clear_i) w_next = IDLE;
  end

  if (HAS_OUT) begin : g_out
    logic r_ov, r_oe;
    logic [WIDTH-1:0] r_od;
`ifdef SFM_REDUCER_ARGIDX_EN
    logic [IDX_W-1:0] r_oi;
`endif
    // Output register: captures the finished result once and holds it until accepted
    always_ff @(posedge clk_i or negedge rst_ni)
      if (!rst_ni) begin
        r_ov <= 1'b0;
        r_oe <= 1'b1;
        r_od <= '0;
`ifdef SFM_REDUCER_ARGIDX_EN
        r_oi <= '0;
`endif
      end else if (clear_i || w_ohs) r_ov <= 1'b0;
      else if (r_state == DONE && !r_ov) begin
        r_ov <= 1'b1;
        r_oe <= ~r_found;
        r_od <= r_acc;
`ifdef SFM_REDUCER_ARGIDX_EN
        r_oi <= r_aidx;
`endif
      end
    assign valid_o = r_ov;
    assign data_o = r_od;
    assign empty_o = r_oe;
`ifdef SFM_REDUCER_ARGIDX_EN
    assign idx_o = r_oi;
`endif
  end else begin : g_no_out
    assign valid_o = r_state == DONE;
    assign data_o = r_acc;
    assign empty_o = ~r_found;
`ifdef SFM_REDUCER_ARGIDX_EN
    assign idx_o = r_aidx;
`endif
  end
endmodule

// File: tb/tb_sfm_minmax_reducer.sv
// tb_sfm_minmax_reducer: directed self-checking bench for sfm_minmax_reducer (AROUND, 4 x fp16)
`ifdef SFM_REDUCER_ARGIDX_EN
`define CHK_IDX(t, v) chk16(t, idx_o, v)
`else
`define CHK_IDX(t, v)
`endif

module tb_sfm_minmax_reducer;
  import sfm_pkg::*;
  logic clk = 1'b0;
  logic rst_ni = 1'b1;
  logic clear_i = 1'b0;
  logic valid_i = 1'b0;
  logic last_i = 1'b0;
  logic ready_i = 1'b0;
  min_max_mode_t mode_i = MIN;
  logic [63:0] data_i = '0;
  logic [3:0] strb_i = '0;
  logic ready_o, valid_o, empty_o;
  logic [15:0] data_o;
`ifdef SFM_REDUCER_ARGIDX_EN
  logic [15:0] idx_o;
`endif
  int checks = 0;
  int failures = 0;

  always #5 clk = ~clk;

  sfm_minmax_reducer #(
    .N_LANES(4), .WIDTH(16), .EXP_BITS(5), .REGS_CONFIG(AROUND), .IDX_W(16)
  ) dut (
    .clk_i(clk), .rst_ni(rst_ni), .clear_i(clear_i), .mode_i(mode_i),
    .valid_i(valid_i), .ready_o(ready_o), .data_i(data_i), .strb_i(strb_i), .last_i(last_i),
    .valid_o(valid_o), .ready_i(ready_i), .data_o(data_o), .empty_o(empty_o)
`ifdef SFM_REDUCER_ARGIDX_EN
    , .idx_o(idx_o)
`endif
  );

  task automatic chk1(input string tag, input logic obs, input logic exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic chk16(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic chk_out(input string tag, input logic [15:0] d, input logic e);
    chk16({tag, "_data"}, data_o, d);
    chk1({tag, "_empty"}, empty_o, e);
  endtask

  task automatic send(input logic [63:0] d, input logic [3:0] s, input logic l);
    int n = 0;
    data_i = d;
    strb_i = s;
    last_i = l;
    valid_i = 1'b1;
    while (!ready_o && n < 20) begin
      @(negedge clk);
      n++;
    end
    chk1("send_ready", ready_o, 1'b1);
    @(posedge clk);
    #1 valid_i = 1'b0;
  endtask

  task automatic wait_valid(input string tag);
    int n = 0;
    while (!valid_o && n < 40) begin
      @(negedge clk);
      n++;
    end
    chk1({tag, "_valid"}, valid_o, 1'b1);
  endtask

  task automatic start(input string tag, input min_max_mode_t m, input logic [63:0] d, input logic [3:0] s);
    mode_i = m;
    send(d, s, 1'b1);
    @(negedge clk);
    wait_valid(tag);
  endtask

  task automatic finish_hs(input string tag);
    ready_i = 1'b1;
    @(negedge clk);
    chk1({tag, "_hs_valid"}, valid_o, 1'b0);
  endtask

  initial begin
    #1 rst_ni = 1'b0;
    repeat (3) @(negedge clk);
    chk1("rst_valid", valid_o, 1'b0);
    chk1("rst_ready", ready_o, 1'b0);
    chk_out("rst", 16'h0000, 1'b1);
    `CHK_IDX("rst_idx", 16'd0);
    rst_ni = 1'b1;
    #1 chk1("rst_ready_after", ready_o, 1'b1);
    @(negedge clk);
    // two-beat MAX with a tie across beats; mode change on beat 2 must be ignored
    ready_i = 1'b0;
    mode_i = MAX;
    send(64'h0000_4200_C000_3C00, 4'hF, 1'b0);
    @(negedge clk);
    mode_i = MIN;
    send(64'hC000_8000_3C00_4200, 4'hF, 1'b1);
    @(negedge clk);
    chk1("lat_c1", valid_o, 1'b0);
    @(negedge clk);
    chk1("lat_c2", valid_o, 1'b0);
    @(negedge clk);
    chk1("lat_c3", valid_o, 1'b1);
    chk_out("tie", 16'h4200, 1'b0);
    `CHK_IDX("tie_idx", 16'd2);
    finish_hs("tie");
    // masked lane and NaN lane excluded
    start("mask", MIN, 64'h4200_C000_7E00_3C00, 4'b1011);
    chk_out("mask", 16'h3C00, 1'b0);
    `CHK_IDX("mask_idx", 16'd0);
    finish_hs("mask");
    start("allnan", MAX, 64'h7FFF_FE00_7C01_7E00, 4'hF);
    chk_out("allnan", 16'h7E00, 1'b1);
    `CHK_IDX("allnan_idx", 16'd0);
    finish_hs("allnan");
    start("nostrb", MIN, 64'h4200_C000_3C00_3C00, 4'h0);
    chk_out("nostrb", 16'h7E00, 1'b1);
    `CHK_IDX("nostrb_idx", 16'd0);
    finish_hs("nostrb");
    start("zmin", MIN, 64'h4400_3C00_8000_0000, 4'hF);
    chk_out("zmin", 16'h0000, 1'b0);
    `CHK_IDX("zmin_idx", 16'd0);
    finish_hs("zmin");
    start("zmax", MAX, 64'h0000_BC00_C000_8000, 4'hF);
    chk_out("zmax", 16'h8000, 1'b0);
    `CHK_IDX("zmax_idx", 16'd0);
    finish_hs("zmax");
    start("infmax", MAX, 64'h7BFF_7C00_FC00_3C00, 4'hF);
    chk_out("infmax", 16'h7C00, 1'b0);
    `CHK_IDX("infmax_idx", 16'd2);
    finish_hs("infmax");
    start("infmin", MIN, 64'h7BFF_7C00_FC00_3C00, 4'hF);
    chk_out("infmin", 16'hFC00, 1'b0);
    `CHK_IDX("infmin_idx", 16'd1);
    finish_hs("infmin");
    // backpressure: result held, next beat fills the input stage, then ready_o drops
    ready_i = 1'b0;
    start("hold", MAX, 64'h0000_0000_0000_3C00, 4'b0001);
    for (int i = 0; i < 5; i++) begin
      chk1("hold_valid", valid_o, 1'b1);
      chk_out("hold", 16'h3C00, 1'b0);
      `CHK_IDX("hold_idx", 16'd0);
      if (i == 0) begin
        chk1("hold_ready_empty", ready_o, 1'b1);
        mode_i = MAX;
        data_i = 64'h0000_0000_0000_4400;
        strb_i = 4'b0001;
        last_i = 1'b1;
        valid_i = 1'b1;
      end else begin
        chk1("hold_ready_full", ready_o, 1'b0);
        valid_i = 1'b0;
      end
      @(negedge clk);
    end
    finish_hs("hold");
    chk1("hold_ready_after", ready_o, 1'b1);
    wait_valid("queued");
    chk_out("queued", 16'h4400, 1'b0);
    `CHK_IDX("queued_idx", 16'd0);
    finish_hs("queued");
    // clear while a result is waiting
    ready_i = 1'b0;
    start("clrdone", MIN, 64'h0000_0000_0000_3C00, 4'b0001);
    clear_i = 1'b1;
    @(negedge clk);
    clear_i = 1'b0;
    chk1("clrdone_valid", valid_o, 1'b0);
    ready_i = 1'b1;
    repeat (4) @(negedge clk);
    chk1("clrdone_quiet", valid_o, 1'b0);
    // clear mid-reduction after two beats
    mode_i = MIN;
    send(64'h3C00_3C00_3C00_3C00, 4'hF, 1'b0);
    @(negedge clk);
    send(64'h4000_4000_4000_4000, 4'hF, 1'b0);
    @(negedge clk);
    clear_i = 1'b1;
    @(negedge clk);
    clear_i = 1'b0;
    chk1("clr_valid", valid_o, 1'b0);
    chk1("clr_ready", ready_o, 1'b1);
    repeat (6) @(negedge clk);
    chk1("clr_quiet", valid_o, 1'b0);
    // reset mid-reduction after two beats
    send(64'h3C00_3C00_3C00_3C00, 4'hF, 1'b0);
    @(negedge clk);
    send(64'h4000_4000_4000_4000, 4'hF, 1'b0);
    @(negedge clk);
    rst_ni = 1'b0;
    #1;
    chk1("mrst_valid", valid_o, 1'b0);
    chk1("mrst_ready", ready_o, 1'b0);
    chk_out("mrst", 16'h0000, 1'b1);
    @(negedge clk);
    rst_ni = 1'b1;
    repeat (6) @(negedge clk);
    chk1("mrst_quiet", valid_o, 1'b0);
    start("after", MIN, 64'hC000_C000_C000_C000, 4'hF);
    chk_out("after", 16'hC000, 1'b0);
    `CHK_IDX("after_idx", 16'd0);
    finish_hs("after");
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule

// File: doc/sfm_minmax_reducer.md
SFM_MINMAX_REDUCER -- requirements
Module: sfm_minmax_reducer

Interface
REQ-001 SHALL have parameter N_LANES, default 4: number of parallel FP lanes per input beat (power of two, at least 1).
REQ-002 SHALL have parameter WIDTH, default 16: FP element width in bits (IEEE-style sign/exponent/mantissa).
REQ-003 SHALL have parameter EXP_BITS, default 5: exponent field width, used for NaN detection.
REQ-004 SHALL have parameter REGS_CONFIG, type sfm_pkg::regs_config_t, default AROUND: BEFORE adds an input stage, AFTER adds an output stage, AROUND adds both.
REQ-005 SHALL have parameter IDX_W, default 16: element-index width.
REQ-006 SHALL have ports clk_i (in, 1, clock) and rst_ni (in, 1, asynchronous active-low reset).
REQ-007 SHALL have ports clear_i (in, 1) for synchronous abort, and mode_i (in, sfm_pkg::min_max_mode_t) selecting MIN or MAX.
REQ-008 SHALL have ports valid_i (in, 1), ready_o (out, 1), data_i (in, N_LANES*WIDTH, lane 0 at the LSBs), strb_i (in, N_LANES, lane-enable mask) and last_i (in, 1, final beat of the reduction).
REQ-009 SHALL have ports valid_o (out, 1), ready_i (in, 1), data_o (out, WIDTH, result) and empty_o (out, 1, no non-NaN element seen).

Function
REQ-010 SHALL be an FSM with states IDLE, ACC and DONE.
- IDLE -> ACC on the first accepted beat with last_i=0.
- IDLE -> DONE on the first accepted beat with last_i=1.
- ACC -> DONE on an accepted beat with last_i=1.
- DONE -> IDLE on the output handshake (valid_o & ready_i).
REQ-011 SHALL accept a beat only when valid_i & ready_o are both high; ready_o SHALL be low while the core is in DONE and the input stage, if present, is full.
REQ-012 SHALL latch mode_i on the first beat of each reduction and ignore later mode_i changes until the return to IDLE.
REQ-013 SHALL compare elements by sign-magnitude: -0 equals +0; lanes with strb_i=0 and NaN elements are excluded.
REQ-014 SHALL resolve ties to the lowest global element index, where index = beat_count*N_LANES + lane.
REQ-015 SHALL implement the per-beat lane reduction as a combinational log2(N_LANES) tree feeding one accumulator register.
REQ-016 SHALL set data_o to canonical quiet NaN (exponent all-ones, mantissa MSB=1, sign 0) and empty_o=1 when no element qualified.
REQ-017 SHALL give a latency from last-beat handshake to valid_o of 2 cycles for BEFORE, 2 for AFTER and 3 for AROUND.
REQ-018 SHALL hold valid_o and all outputs stable while valid_o=1 and ready_i=0.
REQ-019 SHALL on clear_i=1, at the next edge, flush all pipeline stages, go to IDLE and drive valid_o=0; clear_i SHALL take priority over a simultaneous handshake.
REQ-020 SHALL saturate the beat counter at its maximum value rather than wrap.

Reset
REQ-021 SHALL on rst_ni=0 asynchronously force state IDLE, clear all stage valid flags and the accumulator, and drive valid_o=0, ready_o=0, data_o=0, empty_o=1.
REQ-022 SHALL drive ready_o=1 in the first cycle after rst_ni deasserts, and an aborted reduction SHALL produce no output.

Configuration
REQ-023 SHALL, with SFM_REDUCER_ARGIDX_EN defined, add port idx_o (out, IDX_W) holding the global index of the winning element, reset value 0, and 0 when empty_o=1.
REQ-024 SHALL, without SFM_REDUCER_ARGIDX_EN, omit idx_o and all index logic, with identical data_o, empty_o and timing.

Verification
REQ-025 Bench: N_LANES=4, fp16, MAX, beats {3C00,C000,4200,0000} then {4200,3C00,8000,C000} last -> data_o=4200, idx_o=2 (tie, lowest index wins).
REQ-026 Bench: MIN, single beat {3C00,7E00,C000,4200}, last, strb=1011 -> lane 2 masked, NaN excluded -> data_o=3C00, idx_o=0.
REQ-027 Bench: every element NaN, or strb=0000, single last beat -> data_o=7E00, empty_o=1, idx_o=0.
REQ-028 Bench: AROUND, hold ready_i=0 for 5 cycles after valid_o -> outputs stable, ready_o low once the input stage is full, then handshake -> IDLE.
REQ-029 Bench: clear_i and rst_ni pulsed mid-reduction after 2 beats -> no valid_o; the next reduction {C000x4} last under MIN -> data_o=C000, idx_o=0.
